output_pack_reg: RTL and testbench

OUTPUT_PACK_REG -- requirements
Module: output_pack_reg

---
 rtl/bitblade_pkg.sv | 27 ++
 rtl/pack_beat_ctr.sv | 51 +++++
 rtl/output_pack_reg.sv | 125 ++++++++++++
 tb/tb_output_pack_reg.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bitblade_pkg.sv
// Shared definitions for the bitblade lane-result path: packing mode encodings and beats-per-word.
// Latency: n/a (constants and a pure helper function only).
// Backpressure: n/a.
package bitblade_pkg;

  // Packing mode encodings as driven on input_bitwidth (2'b11 behaves as MODE_QUARTER)
  localparam logic [1:0] MODE_FULL    = 2'b00;
  localparam logic [1:0] MODE_HALF    = 2'b01;
  localparam logic [1:0] MODE_QUARTER = 2'b10;

  // Number of accepted beats that make up one 32-bit word in each mode
  localparam logic [2:0] BEATS_FULL    = 3'd1;
  localparam logic [2:0] BEATS_HALF    = 3'd2;
  localparam logic [2:0] BEATS_QUARTER = 3'd4;

  // Index of the beat that completes a word in the given mode
  function automatic logic [1:0] last_beat(input logic [1:0] mode);
    logic [2:0] beats;
    case (mode)
      MODE_FULL: beats = BEATS_FULL;
      MODE_HALF: beats = BEATS_HALF;
      default:   beats = BEATS_QUARTER;
    endcase
    return 2'(beats - 3'd1);
  endfunction

endpackage

// File: rtl/pack_beat_ctr.sv
// Beat counter for the output packer: tracks beats in the current word, latches its mode, flags completion.
// Latency: o_complete is combinational with the accepted beat; count/mode update on the next clock.
// Backpressure: none of its own; it only counts beats the parent reports as accepted.
//
// Ports:
//   i_clk, i_reset   clock and synchronous active-high reset
//   i_bitwidth       live packing mode, sampled only when a word starts (count 0)
//   i_accept         a beat is accepted this cycle
//   i_flush_emit     a partial word is emitted this cycle; restart at beat 0
//   o_cnt            beats already held in the current word
//   o_mode           mode governing the current word
//   o_complete       the accepted beat finishes the word
module pack_beat_ctr
  import bitblade_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [1:0] i_bitwidth,
  input  logic       i_accept,
  input  logic       i_flush_emit,
  output logic [1:0] o_cnt,
  output logic [1:0] o_mode,
  output logic       o_complete
);

  logic [1:0] r_cnt;
  logic [1:0] r_mode;

  // At count 0 no word is in progress, so the live input decides the mode for the
  // incoming beat; afterwards the latched value wins and mid-word changes are ignored.
  assign o_mode     = (r_cnt == 2'd0) ? i_bitwidth : r_mode;
  assign o_cnt      = r_cnt;
  assign o_complete = i_accept && (r_cnt == last_beat(o_mode));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt  <= 2'd0;
      r_mode <= MODE_FULL;
    end else begin
      if (i_accept && (r_cnt == 2'd0)) begin
        r_mode <= i_bitwidth;
      end
      if (o_complete || i_flush_emit) begin
        r_cnt <= 2'd0;
      end else if (i_accept) begin
        r_cnt <= r_cnt + 2'd1;
      end
    end
  end

endmodule

// File: rtl/output_pack_reg.sv
// Packs 8/16/32-bit lane result beats low-to-high into 32-bit words for a buffer write port.
// Latency: a completed (or flushed) word appears on out_valid one cycle after its last beat is accepted.
// Backpressure: in_ready = !out_valid || out_ready; the output word and any flush wait while out_ready is low.
//
// Ports:
//   clk, reset                         clock and synchronous active-high reset
//   input_bitwidth                     00 full word, 01 two halves, 10/11 four bytes
//   in_valid/in_ready/in_data          lane beat handshake and payload
//   flush                              emit the partially assembled word, zero-padded
//   out_valid/out_ready/out_data       packed word handshake
//   out_addr                           buffer word address, only when PACK_ADDR_GEN_EN is defined
module output_pack_reg
  import bitblade_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        input_bitwidth,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_data
`ifdef PACK_ADDR_GEN_EN
  ,
  output logic [ADDR_W-1:0] out_addr
`endif
);

  logic [31:0] r_asm;
  logic        r_flush_pend;
  logic        r_out_vld;
  logic [31:0] r_out_dat;

  logic        w_accept;
  logic [1:0]  w_cnt;
  logic [1:0]  w_mode;
  logic        w_complete;
  logic [31:0] w_lane;
  logic [31:0] w_asm_next;
  logic        w_partial;
  logic        w_flush_req;
  logic        w_load;
  logic        w_flush_emit;

  assign in_ready  = !r_out_vld || out_ready;
  assign w_accept  = in_valid && in_ready;
  assign out_valid = r_out_vld;
  assign out_data  = r_out_dat;

  pack_beat_ctr u_beat_ctr (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_bitwidth   (input_bitwidth),
    .i_accept     (w_accept),
    .i_flush_emit (w_flush_emit),
    .o_cnt        (w_cnt),
    .o_mode       (w_mode),
    .o_complete   (w_complete)
  );

  // Position the beat in its lane; unused payload bits are dropped by the zero-extension.
  always_comb begin
    w_lane = 32'h0;
    case (w_mode)
      MODE_FULL: w_lane = in_data;
      MODE_HALF: w_lane = {16'h0, in_data[15:0]} << {w_cnt[0], 4'b0};
      default:   w_lane = {24'h0, in_data[7:0]} << {w_cnt, 3'b0};
    endcase
  end

  // The assembly register is zero outside filled lanes, so OR-ing places the beat.
  assign w_asm_next = w_accept ? (r_asm | w_lane) : r_asm;

  // Does the word still hold beats after this cycle's accept, short of completing?
  assign w_partial = w_accept ? !w_complete : (w_cnt != 2'd0);

  assign w_flush_req  = flush || r_flush_pend;
  assign w_load       = in_ready && (w_complete || (w_flush_req && w_partial));
  assign w_flush_emit = w_load && !w_complete;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_asm        <= 32'h0;
      r_flush_pend <= 1'b0;
      r_out_vld    <= 1'b0;
      r_out_dat    <= 32'h0;
    end else begin
      if (w_load) begin
        r_asm <= 32'h0;
      end else if (w_accept) begin
        r_asm <= w_asm_next;
      end

      // A flush that finds the slot busy waits; one against an empty word is dropped.
      r_flush_pend <= w_flush_req && !in_ready && (w_cnt != 2'd0);

      // Loading while the current word drains keeps out_valid high with no bubble.
      if (w_load) begin
        r_out_vld <= 1'b1;
        r_out_dat <= w_asm_next;
      end else if (out_ready) begin
        r_out_vld <= 1'b0;
      end
    end
  end

`ifdef PACK_ADDR_GEN_EN
  logic [ADDR_W-1:0] r_addr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr <= '0;
    end else if (r_out_vld && out_ready) begin
      r_addr <= r_addr + 1'b1;
    end
  end

  assign out_addr = r_addr;
`endif

endmodule

// File: tb/tb_output_pack_reg.sv
module tb_output_pack_reg;

  localparam int ADDR_W = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  input_bitwidth;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
`ifdef PACK_ADDR_GEN_EN
  logic [ADDR_W-1:0] out_addr;
`endif

  always #5 clk = ~clk;

  output_pack_reg #(.ADDR_W(ADDR_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .input_bitwidth (input_bitwidth),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .flush          (flush),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data)
`ifdef PACK_ADDR_GEN_EN
    ,
    .out_addr       (out_addr)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // The model keeps the beats of the word being built as a list, the queue of
  // words still owed to the buffer, and whether the output slot is occupied.
  logic [31:0]       sb_q[$];
  logic [31:0]       m_beats[$];
  int                m_bpw      = 1;
  int                m_width    = 32;
  bit                m_vld      = 1'b0;
  bit                m_flush_pend = 1'b0;
  bit                m_zero     = 1'b1;
  logic [ADDR_W-1:0] m_addr     = '0;
  bit                mon_en     = 1'b0;

  function automatic logic [31:0] pack_word(input int width);
    logic [31:0] w = 32'h0;
    for (int k = 0; k < m_beats.size(); k++) w = w | (m_beats[k] << (width * k));
    return w;
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      bit          rdy;
      bit          emit;
      logic [31:0] mask;
      // compare what the DUT shows now
      check("out_valid", 32'(out_valid), 32'(m_vld));
      check("in_ready", 32'(in_ready), 32'(!m_vld || out_ready));
      if (m_vld) begin
        check("out_data", out_data, sb_q[0]);
`ifdef PACK_ADDR_GEN_EN
        check("out_addr", 32'(out_addr), 32'(m_addr));
`endif
      end else if (m_zero) begin
        check("out_data_zero", out_data, 32'h0);
      end

      // advance the model across the coming rising edge
      if (reset) begin
        sb_q.delete();
        m_beats.delete();
        m_vld = 1'b0;
        m_flush_pend = 1'b0;
        m_zero = 1'b1;
        m_addr = '0;
      end else begin
        rdy  = !m_vld || out_ready;
        emit = 1'b0;
        if (m_vld && out_ready) begin
          void'(sb_q.pop_front());
          m_addr = m_addr + 1'b1;
        end
        if (rdy) begin
          if (in_valid) begin
            if (m_beats.size() == 0) begin
              case (input_bitwidth)
                2'b00:   begin m_bpw = 1; m_width = 32; end
                2'b01:   begin m_bpw = 2; m_width = 16; end
                default: begin m_bpw = 4; m_width = 8;  end
              endcase
            end
            mask = (m_width == 32) ? 32'hFFFF_FFFF : ((32'd1 << m_width) - 32'd1);
            m_beats.push_back(in_data & mask);
            if (m_beats.size() == m_bpw) emit = 1'b1;
          end
          if ((flush || m_flush_pend) && m_beats.size() > 0) emit = 1'b1;
          m_flush_pend = 1'b0;
          if (emit) begin
            sb_q.push_back(pack_word(m_width));
            m_beats.delete();
            m_vld  = 1'b1;
            m_zero = 1'b0;
          end else if (m_vld && out_ready) begin
            m_vld = 1'b0;
          end
        end else begin
          m_flush_pend = m_flush_pend || (flush && m_beats.size() > 0);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one beat and hold it until accepted (bounded).
  task automatic send(input logic [1:0] bw, input logic [31:0] d, input bit fl);
    int waited = 0;
    input_bitwidth = bw;
    in_data  = d;
    in_valid = 1'b1;
    flush    = fl;
    while (!in_ready && waited < 100) begin
      step();
      waited++;
    end
    if (waited >= 100) begin
      n_checks++;
      $display("FAIL accept_timeout: in_ready=%0b after 100 cycles, required 1", in_ready);
    end
    step();
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    reset = 1'b1;
    input_bitwidth = 2'b00;
    in_valid = 1'b0;
    in_data = 32'h0;
    flush = 1'b0;
    out_ready = 1'b1;
    step();
    mon_en = 1'b1;
    idle(2);
    reset = 1'b0;
    step();
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);

    // four bytes -> 0x44332211 one cycle after the last beat
    send(2'b10, 32'h11, 1'b0);
    send(2'b10, 32'h22, 1'b0);
    send(2'b10, 32'h33, 1'b0);
    send(2'b10, 32'h44, 1'b0);
    check("quarter_valid", 32'(out_valid), 32'd1);
    check("quarter_data", out_data, 32'h4433_2211);
    idle(2);

    // two halves held under backpressure
    out_ready = 1'b0;
    send(2'b01, 32'h5555_BEEF, 1'b0);
    send(2'b01, 32'h7777_DEAD, 1'b0);
    idle(3);
    check("hold_data", out_data, 32'hDEAD_BEEF);
    check("hold_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    idle(2);

    // flush a partial word, then a flush with nothing assembled
    send(2'b10, 32'hAA, 1'b0);
    send(2'b10, 32'hBB, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_partial", out_data, 32'h0000_BBAA);
    idle(1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_empty", 32'(out_valid), 32'd0);

    // flush coincident with an accepted beat includes it
    send(2'b10, 32'h01, 1'b0);
    send(2'b10, 32'h02, 1'b1);
    check("flush_with_beat", out_data, 32'h0000_0201);
    idle(1);

    // full words back to back
    send(2'b00, 32'h1, 1'b0);
    check("b2b_1", out_data, 32'h1);
    send(2'b00, 32'h2, 1'b0);
    check("b2b_2", out_data, 32'h2);
    send(2'b00, 32'h3, 1'b0);
    check("b2b_3", out_data, 32'h3);
    idle(2);

    // reset mid-word discards it
    send(2'b01, 32'h1234, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midreset_valid", 32'(out_valid), 32'd0);
    check("midreset_data", out_data, 32'h0);
    send(2'b01, 32'h5678, 1'b0);
    send(2'b01, 32'h9ABC, 1'b0);
    check("after_reset_word", out_data, 32'h9ABC_5678);
    idle(1);

    // mode change mid-word is ignored until the next word
    send(2'b10, 32'hA1, 1'b0);
    send(2'b10, 32'hB2, 1'b0);
    send(2'b00, 32'hFFFF_FFC3, 1'b0);
    send(2'b00, 32'hFFFF_FFD4, 1'b0);
    check("mode_latched", out_data, 32'hD4C3_B2A1);
    send(2'b00, 32'hCAFE_F00D, 1'b0);
    check("next_mode_full", out_data, 32'hCAFE_F00D);
    idle(1);

    // randomized traffic, including mode churn, flushes, stalls and resets
    for (int i = 0; i < 2000; i++) begin
      in_valid       = ($urandom_range(0, 3) != 0);
      in_data        = $urandom;
      input_bitwidth = 2'($urandom_range(0, 3));
      flush          = ($urandom_range(0, 7) == 0);
      out_ready      = ($urandom_range(0, 3) != 0);
      reset          = ($urandom_range(0, 299) == 0);
      step();
    end
    reset = 1'b0;
    flush = 1'b0;

    // long stream of full words so the address counter wraps
    out_ready = 1'b1;
    input_bitwidth = 2'b00;
    for (int i = 0; i < 300; i++) begin
      in_valid = 1'b1;
      in_data  = $urandom;
      step();
    end
    in_valid = 1'b0;
    idle(4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
